// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multicycle multiply/divide unit holding the architectural HI/LO registers
// of the MIPS core. Operands come straight from the register file read buses;
// results live in HI/LO until MFHI/MFLO pull them back through writeback.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (>= 1)
//
// Ports:
//   clk    in   single clock, all state updates on posedge
//   reset  in   synchronous, active-high
//   pc     in   PC of the issuing instruction (trace only)
//   A      in   operand rs (busA)
//   B      in   operand rt (busB)
//   op     in   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   start  in   issue op this cycle
//   busy   out  multicycle operation in flight (registered)
//   HI     out  HI register
//   LO     out  LO register
//
// Optional feature: define MULT_DIV_TRACE_EN to print a register-file style
// trace line on every HI/LO write.

module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    typedef enum logic {
        Idle,
        Run
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [31:0] aQ;
    logic [31:0] bQ;
    logic [3:0]  opQ;
    logic [31:0] cnt;

    logic        issueLong;
    logic        isMulQ;
    logic        divSigned;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [63:0] product;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] divisor;
    logic [31:0] uQuot;
    logic [31:0] uRem;
    logic [31:0] quot;
    logic [31:0] rem;

`ifdef MULT_DIV_TRACE_EN
    logic [31:0] pcQ;
`else
    logic        unusedPc;
    assign unusedPc = ^pc;
`endif

    assign issueLong = start && ((op == OpMult) || (op == OpMultu) ||
                                 (op == OpDiv)  || (op == OpDivu));
    assign busy      = (state == Run);

    // State register of the two-state sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= Idle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: leave Idle only on a multicycle issue, return when
    // the down-counter reaches its final cycle.
    always_comb begin
        nextState = state;
        case (state)
            Idle: begin
                if (issueLong) begin
                    nextState = Run;
                end
            end
            Run: begin
                if (cnt == 32'd1) begin
                    nextState = Idle;
                end
            end
            default: nextState = Idle;
        endcase
    end

    // Result arithmetic works only on the latched operands. Division is done
    // on magnitudes and the signs are restored afterwards, which gives
    // truncation toward zero, a remainder carrying the dividend's sign, and
    // 0x80000000 / -1 = 0x80000000 without any special case. The divisor is
    // forced non-zero so the divider never sees zero; that result is discarded.
    always_comb begin
        isMulQ    = (opQ == OpMult) || (opQ == OpMultu);
        divSigned = (opQ == OpDiv);
        mulA      = (opQ == OpMult) ? {{32{aQ[31]}}, aQ} : {32'd0, aQ};
        mulB      = (opQ == OpMult) ? {{32{bQ[31]}}, bQ} : {32'd0, bQ};
        product   = mulA * mulB;
        absA      = (divSigned && aQ[31]) ? (32'd0 - aQ) : aQ;
        absB      = (divSigned && bQ[31]) ? (32'd0 - bQ) : bQ;
        divisor   = (absB == 32'd0) ? 32'd1 : absB;
        uQuot     = absA / divisor;
        uRem      = absA % divisor;
        quot      = (divSigned && (aQ[31] ^ bQ[31])) ? (32'd0 - uQuot) : uQuot;
        rem       = (divSigned && aQ[31]) ? (32'd0 - uRem) : uRem;
    end

    // Datapath: operand capture on issue, MTHI/MTLO writes in Idle, counter
    // countdown and result commit in Run. Starts during Run are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI  <= 32'd0;
            LO  <= 32'd0;
            cnt <= 32'd0;
            aQ  <= 32'd0;
            bQ  <= 32'd0;
            opQ <= 4'd0;
`ifdef MULT_DIV_TRACE_EN
            pcQ <= 32'd0;
`endif
        end else if (state == Idle) begin
            if (start) begin
                case (op)
                    OpMult, OpMultu, OpDiv, OpDivu: begin
                        aQ  <= A;
                        bQ  <= B;
                        opQ <= op;
                        cnt <= ((op == OpMult) || (op == OpMultu)) ?
                               32'(MULT_CYCLES) : 32'(DIV_CYCLES);
`ifdef MULT_DIV_TRACE_EN
                        pcQ <= pc;
`endif
                    end
                    OpMthi: begin
                        HI <= A;
`ifdef MULT_DIV_TRACE_EN
                        $display("@%h: $hi <= %h", pc, A);
`endif
                    end
                    OpMtlo: begin
                        LO <= A;
`ifdef MULT_DIV_TRACE_EN
                        $display("@%h: $lo <= %h", pc, A);
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            cnt <= cnt - 32'd1;
            if (cnt == 32'd1) begin
                if (isMulQ) begin
                    HI <= product[63:32];
                    LO <= product[31:0];
`ifdef MULT_DIV_TRACE_EN
                    $display("@%h: $hi <= %h", pcQ, product[63:32]);
                    $display("@%h: $lo <= %h", pcQ, product[31:0]);
`endif
                end else if (bQ != 32'd0) begin
                    HI <= rem;
                    LO <= quot;
`ifdef MULT_DIV_TRACE_EN
                    $display("@%h: $hi <= %h", pcQ, rem);
                    $display("@%h: $lo <= %h", pcQ, quot);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Scoreboard bench for mult_div_unit. Stimulus pushes the hand-computed
// HI/LO pair and busy length of each multicycle op; a monitor pops and
// compares whenever busy falls. Single-cycle effects (reset, MTHI/MTLO,
// abort) are checked directly by the stimulus.

module tb_mult_div_unit;

    localparam logic [3:0] OpNone  = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } expectT;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    expectT      scoreboard[$];
    int          checks = 0;
    int          errors = 0;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pc   (pc),
        .A    (A),
        .B    (B),
        .op   (op),
        .start(start),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point shared by monitor and stimulus.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one op: wait (bounded) for the unit to be free, drive start for
    // one edge, and optionally queue the expected commit.
    task automatic applyStimulus(input string name, input logic [3:0] opCode,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic push, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input int cycles);
        expectT e;
        int     waited = 0;
        while (busy !== 1'b0 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) begin
            checkOutput({name, "_busyTimeout"}, {31'd0, busy}, 32'd0);
        end
        if (push) begin
            e.name   = name;
            e.hi     = expHi;
            e.lo     = expLo;
            e.cycles = cycles;
            scoreboard.push_back(e);
        end
        pc    = pc + 32'd4;
        op    = opCode;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OpNone;
    endtask

    // Monitor: count busy cycles; on each falling edge of busy pop the next
    // expectation and compare. A fall caused by reset is an abort, not a commit.
    initial begin : monitor
        logic   prevBusy;
        logic   prevReset;
        int     busyCount;
        expectT e;
        prevBusy  = 1'b0;
        prevReset = 1'b1;
        busyCount = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busyCount++;
            end else if (prevBusy === 1'b1) begin
                if (prevReset !== 1'b1) begin
                    if (scoreboard.size() == 0) begin
                        checkOutput("unexpectedCommit", 32'd1, 32'd0);
                    end else begin
                        e = scoreboard.pop_front();
                        checkOutput({e.name, "_HI"}, HI, e.hi);
                        checkOutput({e.name, "_LO"}, LO, e.lo);
                        checkOutput({e.name, "_busyCycles"}, 32'(busyCount),
                                    32'(e.cycles));
                    end
                end
                busyCount = 0;
            end
            prevBusy  = busy;
            prevReset = reset;
        end
    end

    initial begin : stimulus
        int drain;
        reset = 1'b1;
        pc    = 32'h0040_0000;
        A     = 32'd1;
        B     = 32'd0;
        op    = OpMthi;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        op    = OpNone;
        @(negedge clk);
        checkOutput("reset_HI", HI, 32'd0);
        checkOutput("reset_LO", LO, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        applyStimulus("mult", OpMult, 32'hFFFF_FFFE, 32'd3, 1'b1,
                      32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        applyStimulus("multu", OpMultu, 32'hFFFF_FFFE, 32'd3, 1'b1,
                      32'h0000_0002, 32'hFFFF_FFFA, 5);
        applyStimulus("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        applyStimulus("divu", OpDivu, 32'hFFFF_FFF9, 32'd2, 1'b1,
                      32'h0000_0001, 32'h7FFF_FFFC, 10);
        applyStimulus("divOverflow", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                      32'h0000_0000, 32'h8000_0000, 10);

        applyStimulus("mthi", OpMthi, 32'h0000_1234, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        @(negedge clk);
        checkOutput("mthi_HI", HI, 32'h0000_1234);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus("divuByZero", OpDivu, 32'd5, 32'd0, 1'b1,
                      32'h0000_1234, 32'h8000_0000, 10);

        // Mid-op MTLO must be ignored and operand changes must not matter.
        applyStimulus("multIgnoreMtlo", OpMult, 32'd3, 32'd4, 1'b1,
                      32'd0, 32'd12, 5);
        @(posedge clk);
        #1;
        op    = OpMtlo;
        A     = 32'h0000_00AA;
        B     = 32'h0000_0099;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OpNone;
        A     = 32'h7777_7777;
        B     = 32'h5555_5555;

        applyStimulus("multuBackToBack", OpMultu, 32'd1, 32'd1, 1'b1,
                      32'd0, 32'd1, 5);

        applyStimulus("mtlo", OpMtlo, 32'h0000_0055, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        @(negedge clk);
        checkOutput("mtlo_LO", LO, 32'h0000_0055);
        checkOutput("mtlo_HI", HI, 32'd0);
        @(posedge clk);
        #1;

        // Reset during a divide aborts it with no later commit.
        applyStimulus("divAbort", OpDiv, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_HI", HI, 32'd0);
        checkOutput("abort_LO", LO, 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("abortNoCommit_HI", HI, 32'd0);
        checkOutput("abortNoCommit_LO", LO, 32'd0);
        checkOutput("abortNoCommit_busy", {31'd0, busy}, 32'd0);

        drain = 0;
        while (scoreboard.size() != 0 && drain < 50) begin
            @(posedge clk);
            drain++;
        end
        checkOutput("scoreboardDrain", 32'(scoreboard.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
